cdce_serial_readback: RTL

- SPI readback engine for the CDCE62005 clock synthesizer. This is the receive counterpart of the existing serial write path.
- On request it runs two transactions:
  - a 32-bit read-command word on mosi;
  - a 32-bit capture of register contents from miso.
- Captured data is presented as a parallel word with a one-cycle valid strobe.
- Sits beside the command controller and serial writer. It shares cs_n/mosi through the top-level mux and is used to verify configuration after configure_done.

---
 rtl/cdce_spi_pkg.sv | 16 +
 rtl/cdce_spi_shifter.sv | 32 +++
 rtl/cdce_serial_readback.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cdce_spi_pkg.sv
// Shared constants and state encoding for the CDCE62005 SPI paths.
// Used by both the serial writer and the readback engine.
package cdce_spi_pkg;

  localparam logic [3:0] CDCE_READ_INSTR = 4'hE;
  localparam int         CDCE_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    CMD_SHIFT,
    CS_GAP,
    READ_SHIFT,
    DONE
  } cdce_rd_state_e;

endpackage

// File: rtl/cdce_spi_shifter.sv
// Word shift register: parallel load, shift right, serial in at MSB.
// Serial out is bit 0, so words move LSB first in both directions.
module cdce_spi_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_en_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q;

  // Load has priority over shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_en_i) begin
      sr_q <= {ser_i, sr_q[WIDTH-1:1]};
    end
  end

  assign q_o   = sr_q;
  assign ser_o = sr_q[0];

endmodule

// File: rtl/cdce_serial_readback.sv
// CDCE62005 SPI readback: read command word out, register word back in.
// Optional compare against an expected word: CDCE_READBACK_COMPARE_EN.
module cdce_serial_readback
  import cdce_spi_pkg::*;
#(
  parameter int WORD_WIDTH    = CDCE_WORD_WIDTH,
  parameter int CS_GAP_CYCLES = 4,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     start_read,
  input  logic [ADDRESS_WIDTH-1:0] reg_address,
  input  logic                     miso,
`ifdef CDCE_READBACK_COMPARE_EN
  input  logic [WORD_WIDTH-1:0]    expected_data,
  output logic                     mismatch,
`endif
  output logic                     cs_n,
  output logic                     mosi,
  output logic                     busy,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     read_valid
);

  localparam int CW = $clog2(WORD_WIDTH) + 1;

  cdce_rd_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cs_n_q, cs_n_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

  logic                  cmd_load;
  logic                  cmd_shift;
  logic                  cap_shift;
  logic [WORD_WIDTH-1:0] cmd_word;
  logic [WORD_WIDTH-1:0] cmd_q;
  logic                  cmd_ser;
  logic [WORD_WIDTH-1:0] cap_q;
  logic                  cap_ser;
  logic                  accept;
  logic                  word_last;
  logic                  gap_last;

  assign accept    = enable & start_read & ~busy_q;
  assign word_last = (int'(cnt_q) == WORD_WIDTH - 1);
  assign gap_last  = (int'(cnt_q) == CS_GAP_CYCLES - 1);

  // Read command: instruction nibble, then address, zero padded.
  always_comb begin
    cmd_word = '0;
    cmd_word[3:0] = CDCE_READ_INSTR;
    cmd_word[4 +: ADDRESS_WIDTH] = reg_address;
  end

  cdce_spi_shifter #(.WIDTH(WORD_WIDTH)) u_cmd (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (cmd_load),
    .load_val_i (cmd_word),
    .shift_en_i (cmd_shift),
    .ser_i      (1'b0),
    .q_o        (cmd_q),
    .ser_o      (cmd_ser)
  );

  cdce_spi_shifter #(.WIDTH(WORD_WIDTH)) u_cap (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_en_i (cap_shift),
    .ser_i      (miso),
    .q_o        (cap_q),
    .ser_o      (cap_ser)
  );

  logic unused_w;
  assign unused_w = ^{cmd_q, cap_ser};

  // Sequencer next state; cs_n is decided a cycle ahead so it is a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    cmd_load  = 1'b0;
    cmd_shift = 1'b0;
    cap_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_q) busy_d = 1'b0;
        if (accept) begin
          cmd_load = 1'b1;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          state_d  = CMD_SHIFT;
        end
      end
      CMD_SHIFT: begin
        cmd_shift = 1'b1;
        if (word_last) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = CS_GAP;
        end
      end
      CS_GAP: begin
        if (gap_last) begin
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          state_d = READ_SHIFT;
        end
      end
      READ_SHIFT: begin
        cap_shift = 1'b1;
        if (word_last) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        rdata_d = cap_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef CDCE_READBACK_COMPARE_EN
  logic [WORD_WIDTH-1:0] exp_q;
  logic                  mism_q;

  // Bits [3:0] carry the echoed address, so they are not compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q  <= '0;
      mism_q <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) exp_q <= expected_data;
      if (state_q == DONE)
        mism_q <= (cap_q[WORD_WIDTH-1:4] != exp_q[WORD_WIDTH-1:4]);
    end
  end

  assign mismatch = mism_q;
`endif

  assign cs_n       = cs_n_q;
  assign mosi       = (state_q == CMD_SHIFT) & cmd_ser;
  assign busy       = busy_q;
  assign read_data  = rdata_q;
  assign read_valid = valid_q;

endmodule
